// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and a req/ack data memory.
// Stores retire in order in the background; loads hitting a buffered store are forwarded.
module dmem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   input  logic              cpu_read_i,
   input  logic              cpu_write_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              buf_empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int WA_W  = ADDR_W - 2;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WA_W-1:0]   addr_q_r [DEPTH];
   logic [DATA_W-1:0] data_q_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_nxt_s;
   logic [DATA_W-1:0] resp_data_r;
   logic [WA_W-1:0]   resp_addr_r;

   logic              wr_req_s;
   logic              rd_req_s;
   logic [WA_W-1:0]   cpu_word_s;
   logic              fwd_hit_s;
   logic [DATA_W-1:0] fwd_data_s;
   logic              resp_hit_s;
   logic              read_miss_s;
   logic              pop_s;
   logic              can_push_s;
   logic              push_s;

   // A simultaneous read and write is treated as a write only.
   assign wr_req_s    = cpu_write_i;
   assign rd_req_s    = cpu_read_i & ~cpu_write_i;
   assign cpu_word_s  = cpu_addr_i[ADDR_W-1:2];
   assign pop_s       = (state_r == ST_DRAIN) & mem_ack_i;
   assign can_push_s  = (count_r < DEPTH_C) | pop_s;
   assign push_s      = wr_req_s & can_push_s;
   assign resp_hit_s  = (state_r == ST_RESP) & rd_req_s & (cpu_word_s == resp_addr_r);
   assign read_miss_s = rd_req_s & ~resp_hit_s & ~fwd_hit_s;
   assign count_nxt_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
   assign buf_empty_o = (count_r == '0) && (state_r == ST_IDLE);

   // Forwarding search: walk oldest to newest so the newest matching entry wins.
   always_comb begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < count_r) &&
             (addr_q_r[rd_ptr_r + PTR_W'(i)] == cpu_word_s)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = data_q_r[rd_ptr_r + PTR_W'(i)];
         end else begin
            fwd_hit_s  = fwd_hit_s;
         end
      end
   end

   // CPU-side answer: stall decision and load data.
   always_comb begin
      cpu_stall_o = 1'b0;
      cpu_rdata_o = '0;
      if (wr_req_s) begin
         cpu_stall_o = ~can_push_s;
      end else if (rd_req_s) begin
         if (resp_hit_s) begin
            cpu_rdata_o = resp_data_r;
         end else if (fwd_hit_s) begin
            cpu_rdata_o = fwd_data_s;
         end else begin
            cpu_stall_o = 1'b1;
         end
      end else begin
         cpu_stall_o = 1'b0;
      end
   end

   // Next-state and memory-port outputs; outputs hold while a transaction is pending.
   always_comb begin
      state_nxt_s = state_r;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_r)
         ST_IDLE: begin
            if (read_miss_s) begin
               state_nxt_s = ST_READ;
            end else if (count_nxt_s != '0) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {addr_q_r[rd_ptr_r], 2'b00};
            mem_wdata_o = data_q_r[rd_ptr_r];
            if (!mem_ack_i) begin
               state_nxt_s = ST_DRAIN;
            end else if (read_miss_s) begin
               state_nxt_s = ST_READ;
            end else if (count_nxt_s != '0) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = cpu_addr_i;
            if (mem_ack_i) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_RESP: begin
            if (count_nxt_s != '0) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Control registers; reset discards every buffered store.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         resp_data_r <= '0;
         resp_addr_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if ((state_r == ST_READ) && mem_ack_i) begin
            resp_data_r <= mem_rdata_i;
            resp_addr_r <= cpu_word_s;
         end
      end
   end

   // Entry storage; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         addr_q_r[wr_ptr_r] <= cpu_word_s;
         data_q_r[wr_ptr_r] <= cpu_wdata_i;
      end
   end

endmodule
